// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the instruction-fetch / load-store memory port arbiter.
package memarb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DATA  = 1'b1
  } owner_e;

  localparam int STREAK_W = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Handshaked memory-side bus; the arbiter is master, the memory is slave.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              m_req;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic              m_ready;
  logic              m_rvalid;
  logic [DATA_W-1:0] m_rdata;

  modport master (
    output m_req, m_we, m_addr, m_wdata,
    input  m_ready, m_rvalid, m_rdata
  );

  modport slave (
    input  m_req, m_we, m_addr, m_wdata,
    output m_ready, m_rvalid, m_rdata
  );
endinterface

// File: rtl/mem_port_arbiter_chk.sv
// Flags a requester that drops its request while its transaction is in flight.
module mem_port_arbiter_chk (
  input logic clk,
  input logic reset,
  input logic i_busy,
  input logic i_owner_data,
  input logic i_req,
  input logic d_req
);
  a_fetch_req_held: assert property (@(posedge clk) disable iff (reset)
    (i_busy && !i_owner_data) |-> i_req);

  a_data_req_held: assert property (@(posedge clk) disable iff (reset)
    (i_busy && i_owner_data) |-> d_req);
endmodule

// File: rtl/memarb_priority.sv
// Owner selection: data normally wins, but a waiting fetch is forced through
// once MAX_DATA_STREAK consecutive data grants have been made past it.
module memarb_priority
  import memarb_pkg::*;
#(
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   i_req,
  input  logic   d_req,
  input  logic   i_grant,
  output owner_e o_owner
);
  logic [STREAK_W-1:0] r_streak;
  logic                w_starved;

  assign w_starved = i_req && (r_streak == STREAK_W'(MAX_DATA_STREAK));

  always_comb begin
    o_owner = OWN_FETCH;
    if (d_req && !w_starved) begin
      o_owner = OWN_DATA;
    end else begin
      o_owner = OWN_FETCH;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_streak <= '0;
    end else if (i_grant) begin
      if ((o_owner == OWN_FETCH) || !i_req) begin
        r_streak <= '0;
      end else if (r_streak != STREAK_W'(MAX_DATA_STREAK)) begin
        r_streak <= r_streak + 4'd1;
      end
    end
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the fetch and load/store ports,
// one outstanding access at a time, with a single pipeline stall output.
module mem_port_arbiter
  import memarb_pkg::*;
#(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_req,
  input  logic [ADDR_W-1:0]  i_addr,
  output logic [DATA_W-1:0]  i_rdata,
  output logic               i_valid,
  input  logic               d_req,
  input  logic               d_we,
  input  logic [ADDR_W-1:0]  d_addr,
  input  logic [DATA_W-1:0]  d_wdata,
  output logic [DATA_W-1:0]  d_rdata,
  output logic               d_valid,
  mem_port_arbiter_if.master mem,
  output logic               stall
);
  state_e            r_state, w_next;
  owner_e            r_owner, w_sel;
  logic              r_i_valid, r_d_valid;
  logic [DATA_W-1:0] r_i_rdata, r_d_rdata;
  logic              w_grant, w_in_req, w_is_data, w_accept, w_write_done, w_rvalid_hit;

  // No grant in a cycle that is still presenting a read completion: the
  // requester's req is the old one until the following cycle.
  assign w_is_data    = (r_owner == OWN_DATA);
  assign w_in_req     = (r_state == REQ);
  assign w_grant      = (r_state == IDLE) && !r_i_valid && !r_d_valid && (i_req || d_req);
  assign w_accept     = w_in_req && mem.m_ready;
  assign w_write_done = w_accept && w_is_data && d_we;
  assign w_rvalid_hit = (r_state == RESP) && mem.m_rvalid;

  memarb_priority #(.MAX_DATA_STREAK(MAX_DATA_STREAK)) u_prio (
    .clk     (clk),
    .reset   (reset),
    .i_req   (i_req),
    .d_req   (d_req),
    .i_grant (w_grant),
    .o_owner (w_sel)
  );

  mem_port_arbiter_chk u_chk (
    .clk          (clk),
    .reset        (reset),
    .i_busy       (r_state != IDLE),
    .i_owner_data (w_is_data),
    .i_req        (i_req),
    .d_req        (d_req)
  );

  assign mem.m_req   = w_in_req;
  assign mem.m_we    = w_in_req && w_is_data && d_we;
  assign mem.m_addr  = w_is_data ? d_addr : i_addr;
  assign mem.m_wdata = d_wdata;

  assign i_rdata = r_i_rdata;
  assign d_rdata = r_d_rdata;
  assign i_valid = r_i_valid && i_req;
  assign d_valid = (r_d_valid || (w_write_done && !reset)) && d_req;
  assign stall   = (i_req && !i_valid) || (d_req && !d_valid);

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_grant) w_next = REQ;
        else         w_next = IDLE;
      end
      REQ: begin
        if (w_accept) w_next = mem.m_we ? IDLE : RESP;
        else          w_next = REQ;
      end
      RESP: begin
        if (mem.m_rvalid) w_next = IDLE;
        else              w_next = RESP;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_owner   <= OWN_FETCH;
      r_i_valid <= 1'b0;
      r_d_valid <= 1'b0;
      r_i_rdata <= '0;
      r_d_rdata <= '0;
    end else begin
      r_state   <= w_next;
      if (w_grant) r_owner <= w_sel;
      r_i_valid <= w_rvalid_hit && !w_is_data && i_req;
      r_d_valid <= w_rvalid_hit && w_is_data && d_req;
      if (w_rvalid_hit && !w_is_data) r_i_rdata <= mem.m_rdata;
      if (w_rvalid_hit && w_is_data)  r_d_rdata <= mem.m_rdata;
    end
  end
endmodule
